// File: rtl/addsub_defs.sv
// Shared definitions for the slice-serial adder/subtractor: FSM encoding
// and saturation constants.
package addsub_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned SAT_FN_W = 64;

    // Largest positive two's-complement value of a w-bit word, zero-extended.
    function automatic logic [SAT_FN_W-1:0] sat_max(input int unsigned w);
        return (SAT_FN_W'(1) << (w - 1)) - SAT_FN_W'(1);
    endfunction

    // Most negative two's-complement value of a w-bit word, zero-extended.
    function automatic logic [SAT_FN_W-1:0] sat_min(input int unsigned w);
        return SAT_FN_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
module addsub_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/addsub_seq.sv
// Slice-serial two's-complement adder/subtractor with valid/ready handshakes,
// optional saturation and N/Z/V flags.
module addsub_seq
    import addsub_defs::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SAT_MAX  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN  = WIDTH'(sat_min(WIDTH));

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               sat_q, sat_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               ovfl_q, ovfl_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [31:0]        base_c;
    logic [SLICE-1:0]   sl_a_c, sl_b_c, sl_s_c;
    logic               sl_cout_c;
    logic [WIDTH-1:0]   raw_c, fin_c;
    logic               v_c;

    assign base_c = 32'(idx_q) * 32'(SLICE);
    assign sl_a_c = a_q[base_c +: SLICE];
    assign sl_b_c = bx_q[base_c +: SLICE];

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a_c),
        .b    (sl_b_c),
        .cin  (carry_q),
        .s    (sl_s_c),
        .cout (sl_cout_c)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bx_d        = bx_q;
        res_d       = res_q;
        sat_d       = sat_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        ovfl_d      = ovfl_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        // Result as it stands once the current slice is written in.
        raw_c                  = res_q;
        raw_c[base_c +: SLICE] = sl_s_c;
        v_c   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (raw_c[WIDTH-1] != a_q[WIDTH-1]);
        fin_c = raw_c;
        if (sat_q && v_c) begin
            fin_c = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = ST_CALC;
                    a_d        = A;
                    bx_d       = sub ? ~B : B;
                    sat_d      = sat;
                    carry_d    = sub;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            ST_CALC: begin
                res_d   = raw_c;
                carry_d = sl_cout_c;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_DONE;
                    sum_d       = fin_c;
                    ovfl_d      = v_c;
                    zero_d      = (fin_c == '0);
                    neg_d       = fin_c[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            bx_q        <= '0;
            res_q       <= '0;
            sat_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            ovfl_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bx_q        <= bx_d;
            res_q       <= res_d;
            sat_q       <= sat_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            ovfl_q      <= ovfl_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Ovfl      = ovfl_q;
    assign Zero      = zero_q;
    assign Neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq: a 16-bit/4-bit-slice instance
// and an 8-bit single-slice instance sharing one clock and reset.
module tb_addsub_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16-bit, 4 slices
    logic        iv16, ir16, sub16, sat16, ov16, ordy16, ofl16, z16, n16;
    logic [15:0] a16, b16, sum16;
    // 8-bit, single slice
    logic        iv8, ir8, sub8, sat8, ov8, ordy8, ofl8, z8, n8;
    logic [7:0]  a8, b8, sum8;

    addsub_seq #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .sub(sub16), .sat(sat16),
        .out_valid(ov16), .out_ready(ordy16),
        .Sum(sum16), .Ovfl(ofl16), .Zero(z16), .Neg(n16)
    );

    addsub_seq #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .sub(sub8), .sat(sat8),
        .out_valid(ov8), .out_ready(ordy8),
        .Sum(sum8), .Ovfl(ofl8), .Zero(z8), .Neg(n8)
    );

    // Issue one 16-bit operation and count edges until out_valid (bounded).
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st, output int lat);
        a16 = a; b16 = b; sub16 = s; sat16 = st; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; sub16 = ~s; sat16 = ~st;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic st, output int lat);
        a8 = a; b8 = b; sub8 = s; sat8 = st; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; sub8 = ~s; sat8 = ~st;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release16();
        ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy16 = 1'b0;
    endtask

    task automatic release8();
        ordy8 = 1'b1;
        @(posedge clk); #1;
        ordy8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid16: got %b want 0", ov16); end
        checks++; if (ir16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready16: got %b want 1", ir16); end
        checks++; if ({sum16, ofl16, z16, n16} !== 19'h0) begin errors++; $display("FAIL reset_outputs16: got sum=%h v=%b z=%b n=%b want all 0", sum16, ofl16, z16, n16); end
        checks++; if ({ov8, ir8, sum8, ofl8, z8, n8} !== 13'b0_1_00000000_000) begin errors++; $display("FAIL reset_dut8: got ov=%b ir=%b sum=%h v=%b z=%b n=%b want ov=0 ir=1 rest 0", ov8, ir8, sum8, ofl8, z8, n8); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_timing();
        int lat;
        run16(16'h1234, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++; if (sum16 !== 16'h1235) begin errors++; $display("FAIL add_sum: got %h want 1235", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b000) begin errors++; $display("FAIL add_flags: got vzn=%b%b%b want 000", ofl16, z16, n16); end
        checks++; if (ir16 !== 1'b0) begin errors++; $display("FAIL add_in_ready_done: got %b want 0", ir16); end
        release16();
        checks++; if ({ov16, ir16} !== 2'b01) begin errors++; $display("FAIL add_handshake: got ov=%b ir=%b want ov=0 ir=1", ov16, ir16); end
    endtask

    task automatic test_pos_overflow();
        int lat;
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (sum16 !== 16'h8000) begin errors++; $display("FAIL povf_sum: got %h want 8000", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b101) begin errors++; $display("FAIL povf_flags: got vzn=%b%b%b want 101", ofl16, z16, n16); end
        release16();
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat);
        checks++; if (sum16 !== 16'h7FFF) begin errors++; $display("FAIL povf_sat_sum: got %h want 7fff", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b100) begin errors++; $display("FAIL povf_sat_flags: got vzn=%b%b%b want 100", ofl16, z16, n16); end
        release16();
    endtask

    task automatic test_sub();
        int lat;
        run16(16'h0005, 16'h0005, 1'b1, 1'b0, lat);
        checks++; if (sum16 !== 16'h0000) begin errors++; $display("FAIL sub_zero_sum: got %h want 0000", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b010) begin errors++; $display("FAIL sub_zero_flags: got vzn=%b%b%b want 010", ofl16, z16, n16); end
        release16();
        run16(16'h0000, 16'h8000, 1'b1, 1'b1, lat);
        checks++; if (sum16 !== 16'h7FFF) begin errors++; $display("FAIL sub_negmin_sum: got %h want 7fff", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b100) begin errors++; $display("FAIL sub_negmin_flags: got vzn=%b%b%b want 100", ofl16, z16, n16); end
        release16();
        run16(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        checks++; if (sum16 !== 16'h8000) begin errors++; $display("FAIL sub_min_sum: got %h want 8000", sum16); end
        checks++; if ({ofl16, z16, n16} !== 3'b101) begin errors++; $display("FAIL sub_min_flags: got vzn=%b%b%b want 101", ofl16, z16, n16); end
        release16();
    endtask

    task automatic test_backpressure();
        int lat;
        run16(16'h0100, 16'h0020, 1'b0, 1'b0, lat);
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0; iv16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (sum16 !== 16'h0120) begin errors++; $display("FAIL bp_sum[%0d]: got %h want 0120", i, sum16); end
            checks++; if ({ov16, ir16, ofl16, z16, n16} !== 5'b10000) begin errors++; $display("FAIL bp_ctrl[%0d]: got ov/ir/v/z/n=%b%b%b%b%b want 10000", i, ov16, ir16, ofl16, z16, n16); end
        end
        iv16 = 1'b0;
        release16();
        checks++; if ({ov16, ir16} !== 2'b01) begin errors++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", ov16, ir16); end
        checks++; if (sum16 !== 16'h0120) begin errors++; $display("FAIL bp_sum_after_hs: got %h want 0120", sum16); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; sat16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if ({ov16, ir16} !== 2'b01) begin errors++; $display("FAIL rstmid_ctrl: got ov=%b ir=%b want ov=0 ir=1", ov16, ir16); end
        checks++; if (sum16 !== 16'h0000) begin errors++; $display("FAIL rstmid_sum: got %h want 0000", sum16); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL rstmid_abandoned: got out_valid=%b want 0", ov16); end
        run16(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        checks++; if (sum16 !== 16'h0007) begin errors++; $display("FAIL rstmid_next_sum: got %h want 0007", sum16); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
        release16();
    endtask

    task automatic test_single_cycle();
        int lat;
        run8(8'h80, 8'hFF, 1'b0, 1'b0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sc_latency: got %0d want 1", lat); end
        checks++; if (sum8 !== 8'h7F) begin errors++; $display("FAIL sc_sum: got %h want 7f", sum8); end
        checks++; if ({ofl8, z8, n8} !== 3'b100) begin errors++; $display("FAIL sc_flags: got vzn=%b%b%b want 100", ofl8, z8, n8); end
        release8();
        run8(8'h80, 8'hFF, 1'b0, 1'b1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sc_sat_latency: got %0d want 1", lat); end
        checks++; if (sum8 !== 8'h80) begin errors++; $display("FAIL sc_sat_sum: got %h want 80", sum8); end
        checks++; if ({ofl8, z8, n8} !== 3'b101) begin errors++; $display("FAIL sc_sat_flags: got vzn=%b%b%b want 101", ofl8, z8, n8); end
        release8();
    endtask

    initial begin
        rst_n = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; sat16 = 1'b0; ordy16 = 1'b0;
        iv8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0; sat8  = 1'b0; ordy8  = 1'b0;
        test_reset();
        test_add_timing();
        test_pos_overflow();
        test_sub();
        test_backpressure();
        test_reset_mid_calc();
        test_single_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, slice-serial two's-complement adder/subtractor with valid/ready handshakes, optional saturation and N/Z/V flags. It processes SLICE bits per clock through one ripple slice, trading latency for area, and returns a registered result. It serves as the generic arithmetic unit for ALU paths wider than the fixed 4-bit ripple adder/subtractor.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle; NSLICE = WIDTH/SLICE.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sub  in  1  0 selects A+B; 1 selects A−B.
- sat  in  1  1 clamps an overflowed result to the signed max/min.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  result, possibly saturated.
- Ovfl  out  1  raw signed overflow; independent of sat.
- Zero  out  1  Sum == 0.
- Neg  out  1  Sum[WIDTH-1].

## Operation
- FSM has three states: IDLE, CALC and DONE.
- IDLE → CALC on in_valid && in_ready.
  - Latch A, Bx = sub ? ~B : B, and sat.
  - Set carry = sub and slice index = 0.
- CALC: each cycle adds slice idx of A and Bx with the carry register.
  - Write the slice sum into the result register.
  - Update carry and increment idx.
  - On the idx == NSLICE−1 cycle, go to DONE and register the outputs.
- Overflow: V = (A[msb] == Bx[msb]) && (raw[msb] != A[msb]). The final carry-out is discarded.
- Saturation: if sat && V, Sum = A[msb] ? {1,0…0} : {0,1…1}. Otherwise Sum = raw.
- Zero and Neg are computed from the final Sum (after saturation). Ovfl = V.
- DONE: out_valid = 1. Go to IDLE on out_ready.
- Sum and flags stay stable from out_valid rise until the next result is written. They do not clear on handshake.
- in_valid is ignored outside IDLE. A, B, sub and sat are sampled only at acceptance.
- There is no overlap: a new operand cannot be accepted in the same cycle as the output handshake.

## Timing
- Reset (rst_n low at an edge) from any state, including mid-CALC:
  - Next state is IDLE; the in-flight operation is abandoned.
  - out_valid = 0, Sum = 0, Ovfl = 0, Zero = 0, Neg = 0, in_ready = 1.
- Latency: out_valid rises NSLICE edges after the accepting edge.
- Occupancy: at least NSLICE + 2 cycles per operation with out_ready held high.
- in_ready rises on the edge after the output handshake.
- SLICE == WIDTH: CALC lasts one cycle, giving latency 1.
- Backpressure: DONE is held indefinitely; outputs are stable and in_ready stays 0.

## Structure
- Shared package/include `addsub_defs`:
  - FSM state encoding (2-bit localparams).
  - Saturation constant helpers (SAT_MAX/SAT_MIN as functions of WIDTH).
- Sub-module `addsub_slice`: SLICE-bit ripple adder with ports a, b, cin → s, cout, built from the existing 1-bit full-adder cells.
- The top level holds the FSM, operand/result shift registers or indexed registers, the carry flip-flop and the flag logic.
- idx counter width is $clog2(NSLICE), minimum 1.

## Test plan
- Add timing check (WIDTH=16, SLICE=4): 0x1234 + 0x0001 with sub=0, sat=0.
  - Sum = 0x1235, Ovfl/Zero/Neg = 0.
  - out_valid exactly 4 edges after acceptance.
- Positive overflow: 0x7FFF + 0x0001.
  - sat=0: Sum = 0x8000, Ovfl=1, Neg=1.
  - sat=1: Sum = 0x7FFF, Ovfl=1, Neg=0.
- Subtraction:
  - 0x0005 − 0x0005: Sum = 0x0000, Zero=1, Ovfl=0.
  - 0x0000 − 0x8000 with sat=1: Sum = 0x7FFF, Ovfl=1.
  - 0x8000 − 0x0001 with sat=1: Sum = 0x8000, Ovfl=1, Neg=1.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands.
  - Sum and flags unchanged, in_ready=0, no acceptance.
  - Raise out_ready: out_valid drops next edge and in_ready=1.
- Reset mid-CALC: rst_n low on the 2nd CALC cycle.
  - Next edge: state IDLE, out_valid=0, Sum=0, in_ready=1.
  - A following 0x0003 + 0x0004 gives 0x0007.
- Single-cycle configuration (WIDTH=8, SLICE=8): 0x80 + 0xFF.
  - sat=0: Sum = 0x7F, Ovfl=1.
  - sat=1: Sum = 0x80.
  - Latency 1 in both cases.
